execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk  input  1  single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have inputs E_icode, E_ifun  4 each  instruction code/function from the D->E register.
REQ-004 SHALL have inputs E_valA, E_valB, E_valC  64 each, signed  operands from decode.
REQ-005 SHALL have inputs E_dstE, E_dstM  4 each  destination registers (4'hF = none).
REQ-006 SHALL have inputs E_stat, m_stat, W_stat  2 each  status codes (0 AOK, 1 HLT, 2 ADR, 3 INS).
REQ-007 SHALL have input M_bubble  1  pipeline-control request to load a bubble into the E->M register.
REQ-008 SHALL have combinational outputs e_valE (64), e_dstE (4) and e_Cnd (1), used for forwarding into decode.
REQ-009 SHALL have registered outputs M_icode (4), M_Cnd (1), M_valE (64), M_valA (64), M_dstE (4), M_dstM (4) and M_stat (2).
REQ-010 SHALL have output cc  3  registered condition codes {ZF,SF,OF}.

Function
REQ-011 SHALL select aluA as follows: icode 2 or 6 -> E_valA; icode 3, 4 or 5 -> E_valC; icode 8 or A -> -8; icode 9 or B -> +8; otherwise 0.
REQ-012 SHALL select aluB as follows: icode 4, 5, 6, 8, 9, A or B -> E_valB; icode 2 or 3 -> 0; otherwise 0.
REQ-013 SHALL compute, for icode 6, e_valE by ifun: 0 B+A, 1 B-A, 2 B&A, 3 B^A; ifun >3 gives e_valE=0 with no CC update.
REQ-014 SHALL use B+A for every other icode; all arithmetic is 64-bit two's complement and wraps silently.
REQ-015 SHALL compute flags: ZF = (result==0); SF = result[63].
REQ-016 SHALL compute OF for add as: sign(A)==sign(B) and sign(result)!=sign(A).
REQ-017 SHALL compute OF for sub as: sign(B)!=sign(A) and sign(result)!=sign(B).
REQ-018 SHALL force OF=0 for and/xor.
REQ-019 SHALL define set_cc = (E_icode==6) and (ifun<=3) and (m_stat==AOK) and (W_stat==AOK).
REQ-020 SHALL update cc on the next rising edge only when set_cc is high; otherwise cc holds.
REQ-021 SHALL compute e_Cnd combinationally from the current cc register (not the new flags), by ifun: 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; 7-F 0.
REQ-022 SHALL set e_dstE = 4'hF when E_icode==2 and e_Cnd==0; otherwise e_dstE = E_dstE.
REQ-023 SHALL, when M_bubble=0, load on each rising edge: M_icode=E_icode, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_dstE=e_dstE, M_dstM=E_dstM, M_stat=E_stat.
REQ-024 SHALL, when M_bubble=1, load a bubble: M_icode=1 (nop), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=F, M_dstM=F, M_stat=AOK; cc still follows REQ-020.
REQ-025 SHALL give the E->M register a latency of exactly 1 cycle; e_* outputs have zero-cycle latency.
REQ-026 SHALL treat a non-AOK E_stat instruction as passing through unchanged while still suppressing nothing itself; younger-instruction CC suppression is via m_stat/W_stat only.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronously, including mid-operation), drive cc = {1,0,0} and the E->M register to the bubble values of REQ-024.
REQ-028 SHALL resume normal loading on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL take icode, ALU-function, condition-function and stat encodings, plus the constant REG_NONE=4'hF, from a shared package y86_pkg.
REQ-030 SHALL contain exactly one sub-module, alu64, which is combinational (A, B, fun -> result, ZF, SF, OF); CC storage and the E->M register stay in execute_stage.

Verification
REQ-031 SHALL cover: OPq sub, ifun=1, valA=1, valB=1, all stat AOK -> e_valE=0; cc={1,0,0} next cycle.
REQ-032 SHALL cover: add with valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> e_valE=64'hFFFF_FFFF_FFFF_FFFE; cc={0,1,1}.
REQ-033 SHALL cover: cmovle (icode 2, ifun 1), cc={0,1,0}, dstE=3 -> e_Cnd=1, e_dstE=3; with cc={0,0,0} -> e_Cnd=0, e_dstE=F.
REQ-034 SHALL cover: OPq with m_stat=ADR -> cc unchanged; M_valE still equals the ALU result.
REQ-035 SHALL cover: pushq, valB=0x100 -> e_valE=0xF8; popq -> 0x108; M_bubble=1 that cycle -> M_icode=1, M_dstE=F.
REQ-036 SHALL cover: rst_n asserted low between clock edges -> cc={1,0,0} and M_* equal the bubble values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// functions, condition functions, status codes and the E->M register layout.
package y86_pkg;

  localparam int DATA_W = 64;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU functions (ifun of OPq)
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  // Condition functions (ifun of jXX / cmovXX)
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] REG_NONE = 4'hF;

  // Condition-code register, bit order {ZF,SF,OF}
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // E->M pipeline register contents
  typedef struct packed {
    logic [3:0]               icode;
    logic                     cnd;
    logic signed [DATA_W-1:0] val_e;
    logic signed [DATA_W-1:0] val_a;
    logic [3:0]               dst_e;
    logic [3:0]               dst_m;
    logic [1:0]               stat;
  } em_reg_t;

  // A bubble is a nop that writes nothing and reports AOK
  function automatic em_reg_t em_bubble();
    em_reg_t b;
    b.icode = I_NOP;
    b.cnd   = 1'b0;
    b.val_e = '0;
    b.val_a = '0;
    b.dst_e = REG_NONE;
    b.dst_m = REG_NONE;
    b.stat  = STAT_AOK;
    return b;
  endfunction

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit Y86 ALU: computes B op A and the ZF/SF/OF flags.
// Unsupported function codes yield a zero result with OF cleared.
module alu64
  import y86_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [3:0]               fun,
  output logic signed [DATA_W-1:0] result,
  output logic                     zf,
  output logic                     sf,
  output logic                     of
);

  // Operation select and overflow detection from operand/result signs
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = b + a;
        of     = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (b[DATA_W-1] != a[DATA_W-1]) && (result[DATA_W-1] != b[DATA_W-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
    zf = (result == '0);
    sf = result[DATA_W-1];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, condition codes, branch /
// conditional-move evaluation and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               E_icode,
  input  logic [3:0]               E_ifun,
  input  logic signed [DATA_W-1:0] E_valA,
  input  logic signed [DATA_W-1:0] E_valB,
  input  logic signed [DATA_W-1:0] E_valC,
  input  logic [3:0]               E_dstE,
  input  logic [3:0]               E_dstM,
  input  logic [1:0]               E_stat,
  input  logic [1:0]               m_stat,
  input  logic [1:0]               W_stat,
  input  logic                     M_bubble,
  output logic signed [DATA_W-1:0] e_valE,
  output logic [3:0]               e_dstE,
  output logic                     e_Cnd,
  output logic [3:0]               M_icode,
  output logic                     M_Cnd,
  output logic signed [DATA_W-1:0] M_valE,
  output logic signed [DATA_W-1:0] M_valA,
  output logic [3:0]               M_dstE,
  output logic [3:0]               M_dstM,
  output logic [1:0]               M_stat,
  output logic [2:0]               cc
);

  logic signed [DATA_W-1:0] alu_a;
  logic signed [DATA_W-1:0] alu_b;
  logic [3:0]               alu_fun;
  logic                     alu_zf;
  logic                     alu_sf;
  logic                     alu_of;
  logic                     set_cc;
  logic                     lt;
  cc_t                      cc_q;
  em_reg_t                  em_d;
  em_reg_t                  em_q;

  // ALU operand A: register, immediate, or stack-pointer adjustment
  always_comb begin
    alu_a = '0;
    case (E_icode)
      I_RRMOVQ, I_OPQ:             alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:             alu_a = -64'sd8;
      I_RET, I_POPQ:               alu_a = 64'sd8;
      default:                     alu_a = '0;
    endcase
  end

  // ALU operand B: register B for memory/stack/OPq, zero otherwise
  always_comb begin
    alu_b = '0;
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = '0;
    endcase
  end

  // Only OPq picks its own operation; everything else adds
  assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

  alu64 u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fun    (alu_fun),
    .result (e_valE),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Flags are committed only by a valid OPq while no older instruction has faulted
  assign set_cc = (E_icode == I_OPQ) && (E_ifun <= ALU_XOR) &&
                  (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  // Condition-code register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= CC_RESET;
    end else if (set_cc) begin
      cc_q <= '{zf: alu_zf, sf: alu_sf, of: alu_of};
    end
  end

  assign cc = cc_q;
  assign lt = cc_q.sf ^ cc_q.of;

  // Condition evaluation uses the flags already stored, not this cycle's ALU flags
  always_comb begin
    e_Cnd = 1'b0;
    case (E_ifun)
      C_YES:   e_Cnd = 1'b1;
      C_LE:    e_Cnd = lt | cc_q.zf;
      C_L:     e_Cnd = lt;
      C_E:     e_Cnd = cc_q.zf;
      C_NE:    e_Cnd = ~cc_q.zf;
      C_GE:    e_Cnd = ~lt;
      C_G:     e_Cnd = ~lt & ~cc_q.zf;
      default: e_Cnd = 1'b0;
    endcase
  end

  // A conditional move that fails writes no register
  assign e_dstE = ((E_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : E_dstE;

  // Next contents of the E->M register: bubble or the executing instruction
  always_comb begin
    em_d = em_bubble();
    if (!M_bubble) begin
      em_d.icode = E_icode;
      em_d.cnd   = e_Cnd;
      em_d.val_e = e_valE;
      em_d.val_a = E_valA;
      em_d.dst_e = e_dstE;
      em_d.dst_m = E_dstM;
      em_d.stat  = E_stat;
    end
  end

  // E->M pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q <= em_bubble();
    end else begin
      em_q <= em_d;
    end
  end

  assign M_icode = em_q.icode;
  assign M_Cnd   = em_q.cnd;
  assign M_valE  = em_q.val_e;
  assign M_valA  = em_q.val_a;
  assign M_dstE  = em_q.dst_e;
  assign M_dstM  = em_q.dst_m;
  assign M_stat  = em_q.stat;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases followed by
// randomized instructions compared against an arithmetic reference model.
module tb_execute_stage;

  logic               clk;
  logic               rst_n;
  logic [3:0]         E_icode;
  logic [3:0]         E_ifun;
  logic signed [63:0] E_valA;
  logic signed [63:0] E_valB;
  logic signed [63:0] E_valC;
  logic [3:0]         E_dstE;
  logic [3:0]         E_dstM;
  logic [1:0]         E_stat;
  logic [1:0]         m_stat;
  logic [1:0]         W_stat;
  logic               M_bubble;
  logic signed [63:0] e_valE;
  logic [3:0]         e_dstE;
  logic               e_Cnd;
  logic [3:0]         M_icode;
  logic               M_Cnd;
  logic signed [63:0] M_valE;
  logic signed [63:0] M_valA;
  logic [3:0]         M_dstE;
  logic [3:0]         M_dstM;
  logic [1:0]         M_stat;
  logic [2:0]         cc;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] mcc;  // model condition codes {ZF,SF,OF}

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_stat(E_stat), .m_stat(m_stat), .W_stat(W_stat),
    .M_bubble(M_bubble),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_stat(M_stat),
    .cc(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference ALU: what the instruction computes, with overflow judged by
  // whether the exact mathematical result fits in 64 signed bits.
  function automatic void ref_exec(input logic [3:0] icode, input logic [3:0] ifun,
                                   input logic [63:0] va, input logic [63:0] vb,
                                   input logic [63:0] vc,
                                   output logic [63:0] val, output logic [2:0] fl,
                                   output logic op_ok);
    logic [63:0] a;
    logic [63:0] b;
    logic signed [65:0] wa;
    logic signed [65:0] wb;
    logic signed [65:0] exact;
    logic ovf;
    if (icode == 4'h2 || icode == 4'h6) a = va;
    else if (icode >= 4'h3 && icode <= 4'h5) a = vc;
    else if (icode == 4'h8 || icode == 4'hA) a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (icode == 4'h9 || icode == 4'hB) a = 64'd8;
    else a = 64'd0;
    if ((icode >= 4'h4 && icode <= 4'h6) || (icode >= 4'h8 && icode <= 4'hB)) b = vb;
    else b = 64'd0;
    wa = $signed({{2{a[63]}}, a});
    wb = $signed({{2{b[63]}}, b});
    op_ok = 1'b1;
    ovf = 1'b0;
    if (icode != 4'h6 || ifun == 4'h0) begin
      exact = wb + wa;
      val = exact[63:0];
      ovf = (exact > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (exact < -66'sh0_8000_0000_0000_0000);
    end else if (ifun == 4'h1) begin
      exact = wb - wa;
      val = exact[63:0];
      ovf = (exact > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (exact < -66'sh0_8000_0000_0000_0000);
    end else if (ifun == 4'h2) begin
      val = b & a;
    end else if (ifun == 4'h3) begin
      val = b ^ a;
    end else begin
      val = 64'd0;
      op_ok = 1'b0;
    end
    fl = {val == 64'd0, val[63], ovf};
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ifun, input logic [2:0] c);
    logic zf;
    logic less;
    zf = c[2];
    less = c[1] != c[0];
    case (ifun)
      4'h0: return 1'b1;
      4'h1: return less || zf;
      4'h2: return less;
      4'h3: return zf;
      4'h4: return !zf;
      4'h5: return !less;
      4'h6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic setop(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] dste);
    E_icode = icode; E_ifun = ifun;
    E_valA = va; E_valB = vb; E_valC = vc;
    E_dstE = dste; E_dstM = 4'h5;
    E_stat = 2'd0; m_stat = 2'd0; W_stat = 2'd0; M_bubble = 1'b0;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".cc"},      64'(cc),      64'(3'b100));
    check({tag, ".M_icode"}, 64'(M_icode), 64'(4'h1));
    check({tag, ".M_Cnd"},   64'(M_Cnd),   64'd0);
    check({tag, ".M_valE"},  M_valE,       64'd0);
    check({tag, ".M_valA"},  M_valA,       64'd0);
    check({tag, ".M_dstE"},  64'(M_dstE),  64'(4'hF));
    check({tag, ".M_dstM"},  64'(M_dstM),  64'(4'hF));
    check({tag, ".M_stat"},  64'(M_stat),  64'd0);
  endtask

  // Entered #1 after a rising edge with inputs applied; checks the
  // combinational outputs, then the register contents after the next edge.
  task automatic step(input string tag);
    logic [63:0] xv;
    logic [2:0]  xf;
    logic        ok;
    logic        xc;
    logic [3:0]  xd;
    ref_exec(E_icode, E_ifun, E_valA, E_valB, E_valC, xv, xf, ok);
    xc = ref_cnd(E_ifun, mcc);
    xd = (E_icode == 4'h2 && !xc) ? 4'hF : E_dstE;
    @(negedge clk);
    check({tag, ".e_valE"}, e_valE, xv);
    check({tag, ".e_Cnd"},  64'(e_Cnd),  64'(xc));
    check({tag, ".e_dstE"}, 64'(e_dstE), 64'(xd));
    @(posedge clk);
    #1;
    if (E_icode == 4'h6 && ok && m_stat == 2'd0 && W_stat == 2'd0) mcc = xf;
    check({tag, ".cc"}, 64'(cc), 64'(mcc));
    if (M_bubble) begin
      check({tag, ".M_icode"}, 64'(M_icode), 64'(4'h1));
      check({tag, ".M_Cnd"},   64'(M_Cnd),   64'd0);
      check({tag, ".M_valE"},  M_valE,       64'd0);
      check({tag, ".M_valA"},  M_valA,       64'd0);
      check({tag, ".M_dstE"},  64'(M_dstE),  64'(4'hF));
      check({tag, ".M_dstM"},  64'(M_dstM),  64'(4'hF));
      check({tag, ".M_stat"},  64'(M_stat),  64'd0);
    end else begin
      check({tag, ".M_icode"}, 64'(M_icode), 64'(E_icode));
      check({tag, ".M_Cnd"},   64'(M_Cnd),   64'(xc));
      check({tag, ".M_valE"},  M_valE,       xv);
      check({tag, ".M_valA"},  M_valA,       E_valA);
      check({tag, ".M_dstE"},  64'(M_dstE),  64'(xd));
      check({tag, ".M_dstM"},  64'(M_dstM),  64'(E_dstM));
      check({tag, ".M_stat"},  64'(M_stat),  64'(E_stat));
    end
  endtask

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'd0;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  logic [2:0] saved_cc;

  initial begin
    mcc = 3'b100;
    setop(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_bubble("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // OPq add 1+1 moves cc away from its reset value, then sub 1-1 gives zero
    setop(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    step("add_1_1");
    check("add_1_1.cc_lit", 64'(cc), 64'(3'b000));
    setop(4'h6, 4'h1, 64'd1, 64'd1, 64'd0, 4'h2);
    step("sub_zero");
    check("sub_zero.cc_lit", 64'(cc), 64'(3'b100));

    // Positive overflow on add
    setop(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2);
    #1 check("add_ovf.e_valE_lit", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    step("add_ovf");
    check("add_ovf.cc_lit", 64'(cc), 64'(3'b011));

    // cmovle taken when SF set, not taken when all flags clear
    setop(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2);
    step("sub_neg");
    check("sub_neg.cc_lit", 64'(cc), 64'(3'b010));
    setop(4'h2, 4'h1, 64'd42, 64'd0, 64'd0, 4'h3);
    #1;
    check("cmovle_taken.e_Cnd_lit", 64'(e_Cnd), 64'd1);
    check("cmovle_taken.e_dstE_lit", 64'(e_dstE), 64'd3);
    step("cmovle_taken");
    setop(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h2);
    step("add_pos");
    setop(4'h2, 4'h1, 64'd42, 64'd0, 64'd0, 4'h3);
    #1;
    check("cmovle_not.e_Cnd_lit", 64'(e_Cnd), 64'd0);
    check("cmovle_not.e_dstE_lit", 64'(e_dstE), 64'(4'hF));
    step("cmovle_not");

    // An older faulting instruction in M blocks the flag update
    saved_cc = cc;
    setop(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2);
    m_stat = 2'd2;
    step("opq_m_adr");
    check("opq_m_adr.cc_hold", 64'(cc), 64'(saved_cc));
    check("opq_m_adr.M_valE_lit", M_valE, 64'd0);

    // Stack adjustments, with a bubble injected on the popq
    setop(4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4);
    #1 check("pushq.e_valE_lit", e_valE, 64'hF8);
    step("pushq");
    setop(4'hB, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4);
    M_bubble = 1'b1;
    #1 check("popq.e_valE_lit", e_valE, 64'h108);
    step("popq_bubble");
    check("popq_bubble.M_icode_lit", 64'(M_icode), 64'd1);
    check("popq_bubble.M_dstE_lit", 64'(M_dstE), 64'(4'hF));

    // Asynchronous reset asserted between clock edges
    setop(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2);
    step("pre_reset");
    setop(4'h3, 4'h0, 64'd0, 64'd0, 64'd99, 4'h6);
    #2 rst_n = 1'b0;
    #1;
    check_bubble("mid_reset");
    mcc = 3'b100;
    #1 rst_n = 1'b1;
    setop(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    M_bubble = 1'b1;
    @(posedge clk);
    #1;
    setop(4'h3, 4'h0, 64'd0, 64'd0, 64'd99, 4'h6);
    step("post_reset");

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       E_icode = 4'h6;
        1:       E_icode = 4'h2;
        default: E_icode = 4'($urandom_range(0, 15));
      endcase
      E_ifun   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      E_valA   = rand_val();
      E_valB   = rand_val();
      E_valC   = rand_val();
      E_dstE   = 4'($urandom_range(0, 15));
      E_dstM   = 4'($urandom_range(0, 15));
      E_stat   = 2'($urandom_range(0, 3));
      m_stat   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      M_bubble = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
